// File: rtl/or_mux_sequencer.sv
// Sweeps the four A/B combinations into a downstream OR-using-mux stage,
// holds each for HOLD_CYCLES cycles, and scores the returned Out against A|B.
module or_mux_sequencer #(
    parameter int HOLD_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail_idx,
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [15:0] LAST_CNT = 16'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] hold_cnt, hold_cnt_d;
    logic        a_d, b_d, busy_d, done_d, pass_d;
    logic [2:0]  err_d;
    logic [1:0]  ffi_d, vec_d;

    logic sample, last_vec, mismatch;

    // Out is only trusted on the final cycle of each hold window.
    assign sample   = (state_q == DRIVE) && (hold_cnt == LAST_CNT);
    assign last_vec = (vec_idx == 2'd3);
    assign mismatch = (Out != (A | B));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (sample && last_vec) state_d = DONE;
            DONE:    if (start) state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d        = A;
        b_d        = B;
        busy_d     = busy;
        done_d     = done;
        pass_d     = pass;
        err_d      = err_count;
        ffi_d      = first_fail_idx;
        vec_d      = vec_idx;
        hold_cnt_d = hold_cnt;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_d      = '0;
                    ffi_d      = '0;
                    vec_d      = '0;
                    hold_cnt_d = '0;
                end
            end
            DRIVE: begin
                hold_cnt_d = hold_cnt + 16'd1;
                if (sample) begin
                    if (mismatch) begin
                        err_d = err_count + 3'd1;
                        if (err_count == 3'd0) ffi_d = vec_idx;
                    end
                    hold_cnt_d = '0;
                    if (last_vec) begin
                        a_d    = 1'b0;
                        b_d    = 1'b0;
                        vec_d  = '0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        pass_d = (err_d == 3'd0);
                    end else begin
                        // Vector index bits map directly onto {A,B}.
                        vec_d = vec_idx + 2'd1;
                        a_d   = vec_d[1];
                        b_d   = vec_d[0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            A              <= 1'b0;
            B              <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            vec_idx        <= '0;
            hold_cnt       <= '0;
        end else begin
            A              <= a_d;
            B              <= b_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_count      <= err_d;
            first_fail_idx <= ffi_d;
            vec_idx        <= vec_d;
            hold_cnt       <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_or_mux_sequencer.sv
// Directed bench for or_mux_sequencer with HOLD_CYCLES=4; the downstream
// OR stage is modelled here with selectable fault modes.
module tb_or_mux_sequencer;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       A, B, Out;
    logic       busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] first_fail_idx, vec_idx;

    int   mode;     // 0 good OR, 1 stuck-0, 2 stuck-1, 3 good but corrupted off-sample
    logic corrupt;
    int   n_chk  = 0;
    int   n_fail = 0;

    or_mux_sequencer #(.HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Out(Out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .vec_idx(vec_idx)
    );

    always #5 clk = ~clk;

    assign Out = corrupt ? ~(A | B) :
                 (mode == 1) ? 1'b0 :
                 (mode == 2) ? 1'b1 : (A | B);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full sweep from IDLE/DONE; repulse_k > 0 raises start before that edge.
    task automatic run_sweep(input int m, input int repulse_k,
                             input logic [2:0] exp_err, input logic [1:0] exp_ffi,
                             input logic exp_pass);
        logic [1:0] idx;
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 8'(busy), 8'd1);
        chk("start_done", 8'(done), 8'd0);
        chk("start_err", 8'(err_count), 8'd0);
        chk("start_ffi", 8'(first_fail_idx), 8'd0);
        chk("start_ab", 8'({A, B}), 8'd0);
        for (int k = 1; k <= 4 * H; k++) begin
            corrupt = (m == 3) && (((k - 1) % H) != H - 1);
            start   = (k == repulse_k);
            tick();
            start   = 1'b0;
            corrupt = 1'b0;
            if (k < 4 * H) begin
                idx = 2'(k / H);
                chk("drv_busy", 8'(busy), 8'd1);
                chk("drv_done", 8'(done), 8'd0);
                chk("drv_pass", 8'(pass), 8'd0);
                chk("drv_vec", 8'(vec_idx), 8'(idx));
                chk("drv_ab", 8'({A, B}), 8'(idx));
            end
        end
        chk("end_done", 8'(done), 8'd1);
        chk("end_busy", 8'(busy), 8'd0);
        chk("end_ab", 8'({A, B}), 8'd0);
        chk("end_vec", 8'(vec_idx), 8'd0);
        chk("end_err", 8'(err_count), 8'(exp_err));
        chk("end_ffi", 8'(first_fail_idx), 8'(exp_ffi));
        chk("end_pass", 8'(pass), 8'(exp_pass));
        tick();
        chk("hold_done", 8'(done), 8'd1);
        chk("hold_err", 8'(err_count), 8'(exp_err));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 0; corrupt = 1'b0;
        tick(); tick();
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_pass", 8'(pass), 8'd0);
        chk("rst_err", 8'(err_count), 8'd0);
        chk("rst_ab", 8'({A, B}), 8'd0);
        chk("rst_vec", 8'(vec_idx), 8'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 8'(busy), 8'd0);

        run_sweep(0, 0, 3'd0, 2'd0, 1'b1);   // good OR
        run_sweep(1, 0, 3'd3, 2'd1, 1'b0);   // stuck-0
        run_sweep(2, 0, 3'd1, 2'd0, 1'b0);   // stuck-1, started from DONE with errors
        run_sweep(0, 6, 3'd0, 2'd0, 1'b1);   // start re-pulsed mid-sweep
        run_sweep(3, 0, 3'd0, 2'd0, 1'b1);   // off-sample corruption ignored

        // Reset mid-sweep while vec_idx==2
        mode = 0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 2 * H + 1; k++) tick();
        chk("pre_rst_vec", 8'(vec_idx), 8'd2);
        rst = 1'b1;
        tick();
        chk("mid_rst_ab", 8'({A, B}), 8'd0);
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_done", 8'(done), 8'd0);
        chk("mid_rst_err", 8'(err_count), 8'd0);
        chk("mid_rst_vec", 8'(vec_idx), 8'd0);
        start = 1'b1;
        tick();
        chk("rst_vs_start_busy", 8'(busy), 8'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("after_rst_busy", 8'(busy), 8'd0);
        chk("after_rst_done", 8'(done), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/or_mux_sequencer.md
OR_MUX_SEQUENCER -- requirements
Module: or_mux_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 100, meaning clock cycles each A/B vector is held before Out is sampled (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to run the 4-vector sweep.
REQ-005 SHALL have port A  output  1  operand A driven to the downstream OR-using-mux stage.
REQ-006 SHALL have port B  output  1  operand B driven to the downstream OR-using-mux stage.
REQ-007 SHALL have port Out  input  1  result returned from the downstream OR-using-mux stage.
REQ-008 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done  output  1  high from sweep completion until next start or reset.
REQ-010 SHALL have port pass  output  1  high when done and err_count == 0.
REQ-011 SHALL have port err_count  output  3  number of mismatching samples in the last sweep (0..4).
REQ-012 SHALL have port first_fail_idx  output  2  index of first mismatching vector; 0 if none.
REQ-013 SHALL have port vec_idx  output  2  index of vector currently driven.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, DONE; all outputs registered.
REQ-015 SHALL drive vectors in fixed order idx0 A=0,B=0; idx1 A=0,B=1; idx2 A=1,B=0; idx3 A=1,B=1.
REQ-016 SHALL, in IDLE or DONE with start=1 at edge t0, enter DRIVE at t0+1 with vec_idx=0, hold counter=0, err_count=0, first_fail_idx=0, done=0, busy=1.
REQ-017 SHALL hold each vector exactly HOLD_CYCLES cycles; hold counter increments every DRIVE cycle.
REQ-018 SHALL sample Out only on the edge where hold counter == HOLD_CYCLES-1; Out values in other cycles are ignored.
REQ-019 SHALL count a mismatch when sampled Out != (A | B); on the first mismatch of a sweep, first_fail_idx SHALL capture vec_idx.
REQ-020 SHALL, after sampling idx0..idx2, advance vec_idx by 1 and reset hold counter on the same edge.
REQ-021 SHALL, after sampling idx3, enter DONE: busy=0, done=1, A=B=0, vec_idx=0; err_count/first_fail_idx held.
REQ-022 SHALL keep busy high for exactly 4*HOLD_CYCLES cycles; done first high at cycle t0+4*HOLD_CYCLES+1.
REQ-023 SHALL ignore start while busy (no restart, no counter effect).
REQ-024 SHALL assert pass only when done=1 and err_count=0; pass=0 in IDLE and DRIVE.
REQ-025 SHALL drive A=B=0 in IDLE and DONE.

Reset
REQ-026 SHALL, when rst=1 at any edge including mid-sweep, enter IDLE with A=0, B=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, vec_idx=0, hold counter=0.
REQ-027 SHALL give rst priority over start in the same cycle.

Verification
REQ-028 SHALL verify: HOLD_CYCLES=4, correct OR model on Out, start pulse -> A/B = 00,01,10,11 each 4 cycles, done=1 at t0+17, pass=1, err_count=0.
REQ-029 SHALL verify: HOLD_CYCLES=4, Out stuck at 0 -> err_count=3, first_fail_idx=1, pass=0, done=1.
REQ-030 SHALL verify: HOLD_CYCLES=4, Out stuck at 1 -> err_count=1, first_fail_idx=0, pass=0.
REQ-031 SHALL verify: start re-pulsed during busy -> no effect, done still at t0+17; start in DONE -> new sweep, err_count cleared at next edge.
REQ-032 SHALL verify: rst asserted while vec_idx=2 -> next edge A=B=0, busy=0, done=0, err_count=0; then start with rst=1 same cycle -> stays IDLE.
REQ-033 SHALL verify: correct model but Out forced wrong on non-sample cycles (hold counter 0..2) -> err_count=0, pass=1.
